// File: rtl/sfx_mixer_if.sv
// sfx_mixer_if: groups the sound-effect mixer's control, ROM and output signals.
//   trig/loop/atten : per-channel control from game-event logic
//   rom_addr/rom_q  : shared sample ROM port ({channel, position} -> data, 1-cycle latency)
//   sample_out/sample_valid : mixed mono sample and its update strobe
//   busy            : per-channel active-or-pending status
// master = the mixer, slave = the surrounding system (event logic, ROM, CODEC path).
interface sfx_mixer_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 24
);
    localparam int ROM_AW = $clog2(NUM_CH) + ADDR_W;

    logic [NUM_CH-1:0]   trig;
    logic [NUM_CH-1:0]   loop;
    logic [2*NUM_CH-1:0] atten;
    logic [ROM_AW-1:0]   rom_addr;
    logic [DATA_W-1:0]   rom_q;
    logic [DATA_W-1:0]   sample_out;
    logic                sample_valid;
    logic [NUM_CH-1:0]   busy;

    modport master (
        input  trig, loop, atten, rom_q,
        output rom_addr, sample_out, sample_valid, busy
    );

    modport slave (
        output trig, loop, atten, rom_q,
        input  rom_addr, sample_out, sample_valid, busy
    );
endinterface

// File: rtl/sfx_mixer.sv
// sfx_mixer: multi-channel sound-effect player and mixer.
// Once per CLK_DIV clocks it scans every channel through one shared ROM port,
// sums the attenuated samples, applies master gain with saturation and emits
// one mono sample. Channels start/restart on trig rising edges.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : sfx_mixer_if master (trig, loop, atten, rom_addr, rom_q,
//           sample_out, sample_valid, busy)
//
// state   | meaning
// S_IDLE  | waiting for the sample tick
// S_FETCH | one ROM address per channel; accumulate previous channel's data
// S_DRAIN | accumulate the last channel's data
// S_OUT   | saturate and publish the sample, advance channel positions
module sfx_mixer #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 24,
    parameter int SAMPLE_LEN = 32768,
    parameter int CLK_DIV    = 1024,
    parameter int OUT_SHIFT  = 2
) (
    input logic          clk,
    input logic          reset,
    sfx_mixer_if.master  bus
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ROM_AW = $clog2(NUM_CH) + ADDR_W;
    localparam int ACC_W  = DATA_W + $clog2(NUM_CH) + OUT_SHIFT + 1;
    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_POS = ADDR_W'(SAMPLE_LEN - 1);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(64'sd1 <<< (DATA_W - 1)));

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUT} state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_CH-1:0]       trig_prev_q, pending_q, pending_d, active_q, active_d;
    logic [ADDR_W-1:0]       pos_q [NUM_CH];
    logic [ADDR_W-1:0]       pos_d [NUM_CH];
    logic [CH_W-1:0]         ch_q, ch_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]       sample_out_q, sample_out_d;
    logic                    sample_valid_q, sample_valid_d;

    logic                    tick, acc_clr, acc_en, fetch, do_out;
    logic [CH_W-1:0]         src_ch;
    logic [ROM_AW-1:0]       rom_addr;
    logic [NUM_CH-1:0]       rise;
    logic signed [ACC_W-1:0] rom_ext, term, shifted, sat;

    assign tick = (cnt_q == CNT_LAST);
    assign rise = bus.trig & ~trig_prev_q;

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (tick) state_d = S_FETCH;
            S_FETCH: if (ch_q == LAST_CH) state_d = S_DRAIN;
            S_DRAIN: state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs. ROM data for the channel addressed in one FETCH cycle is
    // accumulated in the following cycle, hence src_ch lags ch_q by one.
    always_comb begin
        rom_addr = '0;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        fetch    = 1'b0;
        do_out   = 1'b0;
        src_ch   = ch_q - 1'b1;
        case (state_q)
            S_IDLE:  acc_clr = tick;
            S_FETCH: begin
                fetch    = 1'b1;
                rom_addr = ROM_AW'({ch_q, pos_q[ch_q]});
                acc_en   = (ch_q != '0);
            end
            S_DRAIN: begin
                acc_en = 1'b1;
                src_ch = LAST_CH;
            end
            S_OUT:   do_out = 1'b1;
            default: ;
        endcase
    end

    // Datapath and channel state
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;

        ch_d = ch_q;
        if (acc_clr)    ch_d = '0;
        else if (fetch) ch_d = ch_q + 1'b1;

        rom_ext = ACC_W'($signed(bus.rom_q));
        term    = active_q[src_ch] ? (rom_ext >>> bus.atten[2*src_ch +: 2]) : '0;
        acc_d   = acc_q;
        if (acc_clr)     acc_d = '0;
        else if (acc_en) acc_d = acc_q + term;

        shifted = acc_q <<< OUT_SHIFT;
        if (shifted > SAT_HI)      sat = SAT_HI;
        else if (shifted < SAT_LO) sat = SAT_LO;
        else                       sat = shifted;

        sample_out_d   = do_out ? sat[DATA_W-1:0] : sample_out_q;
        sample_valid_d = do_out;

        // Edges seen in the OUT cycle itself survive into the next period.
        pending_d = do_out ? rise : (pending_q | rise);
        active_d  = active_q;
        pos_d     = pos_q;
        if (do_out) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (pending_q[i]) begin
                    pos_d[i]    = '0;
                    active_d[i] = 1'b1;
                end else if (active_q[i] && pos_q[i] == LAST_POS) begin
                    pos_d[i]    = '0;
                    active_d[i] = bus.loop[i];
                end else if (active_q[i]) begin
                    pos_d[i] = pos_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q          <= '0;
            trig_prev_q    <= '1;   // a trigger held through reset must not fire
            pending_q      <= '0;
            active_q       <= '0;
            ch_q           <= '0;
            acc_q          <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) pos_q[i] <= '0;
        end else begin
            cnt_q          <= cnt_d;
            trig_prev_q    <= bus.trig;
            pending_q      <= pending_d;
            active_q       <= active_d;
            ch_q           <= ch_d;
            acc_q          <= acc_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            pos_q          <= pos_d;
        end
    end

    assign bus.rom_addr     = rom_addr;
    assign bus.sample_out   = sample_out_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.busy         = active_q | pending_q;
endmodule

// File: tb/tb_sfx_mixer.sv
module tb_sfx_mixer;
    localparam int NCH = 2, AW = 2, DW = 16, DW2 = 12, DIV = 16, LEN = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sfx_mixer_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW))  bus1();
    sfx_mixer_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW2)) bus2();

    sfx_mixer #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .SAMPLE_LEN(LEN),
                .CLK_DIV(DIV), .OUT_SHIFT(0))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    sfx_mixer #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW2), .SAMPLE_LEN(LEN),
                .CLK_DIV(DIV), .OUT_SHIFT(0))
        dut2 (.clk(clk), .reset(reset), .bus(bus2));

    // ROM models, one-cycle registered latency
    int sat_val = 0;
    always @(posedge clk)
        bus1.rom_q <= DW'(1000 * (int'(bus1.rom_addr[AW]) + 1) + int'(bus1.rom_addr[AW-1:0]));
    always @(posedge clk)
        bus2.rom_q <= DW2'(sat_val);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0, miscompares = 0, last_valid = 0;

    // Reference model: per-channel playback state, advanced once per sample
    int              m_pos  [NCH];
    bit              m_act  [NCH];
    bit              m_pend [NCH];
    logic [NCH-1:0]  trig_lvl = '0;
    logic [NCH-1:0]  loop_v   = '0;
    logic [2*NCH-1:0] atten_v = '0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_pos[c] = 0; m_act[c] = 0; m_pend[c] = 0;
        end
    endfunction

    function automatic int model_sample();
        int s = 0;
        for (int c = 0; c < NCH; c++)
            if (m_act[c]) s += (1000 * (c + 1) + m_pos[c]) >>> int'(atten_v[2*c +: 2]);
        return s;
    endfunction

    function automatic void model_out();
        for (int c = 0; c < NCH; c++) begin
            if (m_pend[c]) begin
                m_pos[c] = 0; m_act[c] = 1; m_pend[c] = 0;
            end else if (m_act[c] && m_pos[c] == LEN - 1) begin
                m_pos[c] = 0; m_act[c] = loop_v[c];
            end else if (m_act[c]) begin
                m_pos[c]++;
            end
        end
    endfunction

    function automatic int model_busy();
        int b = 0;
        for (int c = 0; c < NCH; c++) if (m_act[c] || m_pend[c]) b |= (1 << c);
        return b;
    endfunction

    function automatic int clamp12(input int v);
        if (v > 2047)  return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    task automatic apply_cfg();
        bus1.loop  = loop_v;
        bus1.atten = atten_v;
    endtask

    task automatic set_trig(input logic [NCH-1:0] v);
        for (int c = 0; c < NCH; c++) if (v[c] && !trig_lvl[c]) m_pend[c] = 1;
        trig_lvl  = v;
        bus1.trig = v;
        @(negedge clk);
    endtask

    task automatic next_sample(input string tag, input int gap);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus1.sample_valid !== 1'b1 && n < 64);
        check({tag, "_valid"}, bus1.sample_valid, 1);
        check({tag, "_gap"}, cyc - last_valid, gap);
        last_valid = cyc;
        check(tag, $signed(bus1.sample_out), model_sample());
        model_out();
        check({tag, "_busy"}, bus1.busy, model_busy());
    endtask

    initial begin
        logic [NCH-1:0] r;
        int k;

        reset = 1'b1;
        bus1.trig = '0; bus1.loop = '0; bus1.atten = '0;
        bus2.trig = '0; bus2.loop = '0; bus2.atten = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_sample_out", $signed(bus1.sample_out), 0);
        check("rst_valid", bus1.sample_valid, 0);
        check("rst_busy", bus1.busy, 0);
        check("rst_rom_addr", bus1.rom_addr, 0);

        reset = 1'b0;
        last_valid = cyc;
        next_sample("first", DIV + NCH + 2);
        next_sample("idle", DIV);

        // single shot on channel 0
        set_trig(2'b01);
        repeat (6) next_sample("ch0_once", DIV);

        // both channels, then with channel 1 attenuated by one
        set_trig(2'b00);
        set_trig(2'b11);
        repeat (6) next_sample("both", DIV);
        set_trig(2'b00);
        atten_v = 4'b0100; apply_cfg();
        set_trig(2'b11);
        repeat (6) next_sample("both_atten", DIV);
        atten_v = '0; apply_cfg();

        // looping, then loop cleared part-way through a pass
        set_trig(2'b00);
        loop_v = 2'b01; apply_cfg();
        set_trig(2'b01);
        repeat (10) next_sample("loop", DIV);
        loop_v = 2'b00; apply_cfg();
        repeat (6) next_sample("loop_stop", DIV);

        // retrigger with position 2 pending playback
        loop_v = 2'b01; apply_cfg();
        set_trig(2'b00);
        set_trig(2'b01);
        repeat (3) next_sample("retrig_lead", DIV);
        set_trig(2'b00);
        set_trig(2'b01);
        repeat (2) next_sample("retrig", DIV);

        // trigger edge arriving in the middle of FETCH
        repeat (12) @(negedge clk);
        check("rom_addr_fetch", bus1.rom_addr, m_pos[0]);
        set_trig(2'b00);
        set_trig(2'b01);
        repeat (2) next_sample("fetch_edge", DIV);

        // saturation on the 12-bit instance
        sat_val = 2000;
        bus2.loop = 2'b11;
        bus2.trig = 2'b11;
        next_sample("sat_warm", DIV);
        check("sat2_idle", $signed(bus2.sample_out), 0);
        next_sample("sat_hi_step", DIV);
        check("sat2_hi", $signed(bus2.sample_out), clamp12(2 * 2000));
        sat_val = -2000;
        next_sample("sat_lo_step", DIV);
        check("sat2_lo", $signed(bus2.sample_out), clamp12(2 * -2000));
        sat_val = 700;
        next_sample("sat_mid_step", DIV);
        check("sat2_mid", $signed(bus2.sample_out), clamp12(2 * 700));
        bus2.trig = 2'b00;

        // randomized triggers, loops and attenuation
        for (int it = 0; it < 40; it++) begin
            loop_v  = NCH'($urandom_range(0, 3));
            atten_v = (2*NCH)'($urandom_range(0, 15));
            apply_cfg();
            k = $urandom_range(0, 8);
            repeat (k) @(negedge clk);
            r = NCH'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) set_trig(trig_lvl & ~r);
            set_trig(r);
            next_sample("rand", DIV);
        end

        // reset in the middle of a scan with channel 0 playing, trig held high
        atten_v = '0; loop_v = 2'b01; apply_cfg();
        set_trig(2'b00);
        set_trig(2'b01);
        repeat (2) next_sample("pre_rst", DIV);
        repeat (12) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_sample_out", $signed(bus1.sample_out), 0);
        check("midrst_valid", bus1.sample_valid, 0);
        check("midrst_busy", bus1.busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        last_valid = cyc;
        next_sample("post_rst", DIV + NCH + 2);
        next_sample("post_rst2", DIV);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
